// File: rtl/pc_incrementer.sv
// Up/down step counter with load, wrap or saturate boundary mode and a carry pulse.
// Define PC_INCREMENTER_STICKY_STAT_EN to make stat a sticky flag cleared via stat_clr.
module pc_incrementer #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 2,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
`ifdef PC_INCREMENTER_STICKY_STAT_EN
    input  logic              stat_clr,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              carry,
    output logic              stat
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             stat_q, stat_d;

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum      = {1'b0, count_q} + step_ext;
    assign diff     = {1'b0, count_q} - step_ext;

    // The extra top bit of sum/diff is the overflow/underflow indication.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (dir) begin
                carry_d = diff[WIDTH];
                if ((SATURATE != 0) && diff[WIDTH]) begin
                    count_d = '0;
                end else begin
                    count_d = diff[WIDTH-1:0];
                end
            end else begin
                carry_d = sum[WIDTH];
                if ((SATURATE != 0) && sum[WIDTH]) begin
                    count_d = '1;
                end else begin
                    count_d = sum[WIDTH-1:0];
                end
            end
        end
    end

    // A new carry event wins over a simultaneous clear.
    always_comb begin
`ifdef PC_INCREMENTER_STICKY_STAT_EN
        stat_d = carry_d | (stat_q & ~stat_clr);
`else
        stat_d = carry_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
            stat_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            stat_q  <= stat_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign stat  = stat_q;

endmodule

// File: tb/tb_pc_incrementer.sv
// Bench for pc_incrementer: wrap and saturate instances (WIDTH=4, STEP_W=2) checked
// against an integer-arithmetic reference model with directed and random steps.
module tb_pc_incrementer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] step = 2'd0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       stat_clr = 1'b0;

    logic [3:0] count_w, count_s;
    logic       carry_w, carry_s;
    logic       stat_w, stat_s;

    int checks = 0;
    int failures = 0;

    int exp_count [2];
    bit exp_carry [2];
    bit exp_stat  [2];

    always #5 clk = ~clk;

    pc_incrementer #(.WIDTH(4), .STEP_W(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .step(step),
        .load(load), .load_val(load_val),
`ifdef PC_INCREMENTER_STICKY_STAT_EN
        .stat_clr(stat_clr),
`endif
        .count(count_w), .carry(carry_w), .stat(stat_w)
    );

    pc_incrementer #(.WIDTH(4), .STEP_W(2), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .step(step),
        .load(load), .load_val(load_val),
`ifdef PC_INCREMENTER_STICKY_STAT_EN
        .stat_clr(stat_clr),
`endif
        .count(count_s), .carry(carry_s), .stat(stat_s)
    );

    // Reference: plain integer add/subtract, then clamp or fold back into 0..15.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int n;
            bit cy;
            cy = 1'b0;
            n  = exp_count[i];
            if (!rst_n) begin
                n = 0;
            end else if (load) begin
                n = int'(load_val);
            end else if (en) begin
                n  = dir ? exp_count[i] - int'(step) : exp_count[i] + int'(step);
                cy = (n < 0) || (n > 15);
                if (n > 15) n = (i == 1) ? 15 : n - 16;
                else if (n < 0) n = (i == 1) ? 0 : n + 16;
            end
            exp_count[i] = n;
            exp_carry[i] = cy;
            if (!rst_n) begin
                exp_stat[i] = 1'b0;
            end else begin
`ifdef PC_INCREMENTER_STICKY_STAT_EN
                exp_stat[i] = cy | (exp_stat[i] & ~stat_clr);
`else
                exp_stat[i] = cy;
`endif
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] obs_count [2];
        logic       obs_carry [2];
        logic       obs_stat  [2];
        obs_count[0] = count_w; obs_carry[0] = carry_w; obs_stat[0] = stat_w;
        obs_count[1] = count_s; obs_carry[1] = carry_s; obs_stat[1] = stat_s;
        for (int i = 0; i < 2; i++) begin
            checks++;
            assert (obs_count[i] === 4'(exp_count[i])) else begin
                failures++;
                $error("[TB] FAIL %s count sat=%0d observed=%0d expected=%0d", tag, i, obs_count[i], exp_count[i]);
            end
            checks++;
            assert (obs_carry[i] === exp_carry[i]) else begin
                failures++;
                $error("[TB] FAIL %s carry sat=%0d observed=%0b expected=%0b", tag, i, obs_carry[i], exp_carry[i]);
            end
            checks++;
            assert (obs_stat[i] === exp_stat[i]) else begin
                failures++;
                $error("[TB] FAIL %s stat sat=%0d observed=%0b expected=%0b", tag, i, obs_stat[i], exp_stat[i]);
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit l, input logic [3:0] lv, input bit e,
                                 input bit d, input logic [1:0] st, input bit clr, input string tag);
        rst_n    = r;
        load     = l;
        load_val = lv;
        en       = e;
        dir      = d;
        step     = st;
        stat_clr = clr;
        @(posedge clk);
        model_update();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_count[i] = 0;
            exp_carry[i] = 1'b0;
            exp_stat[i]  = 1'b0;
        end

        applyStimulus(0, 0, 4'd0, 0, 0, 2'd0, 0, "reset0");
        applyStimulus(0, 0, 4'd0, 1, 0, 2'd3, 0, "reset1");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd1, 0, "first_step");

        applyStimulus(1, 1, 4'd14, 0, 0, 2'd0, 0, "load14");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd3, 0, "up_overflow");
        applyStimulus(1, 0, 4'd0, 0, 0, 2'd3, 0, "carry_drop");

        applyStimulus(1, 1, 4'd2, 0, 0, 2'd0, 0, "load2");
        applyStimulus(1, 0, 4'd0, 1, 1, 2'd3, 0, "down_underflow");
        applyStimulus(1, 0, 4'd0, 1, 1, 2'd3, 0, "down_again");

        applyStimulus(1, 1, 4'd15, 0, 0, 2'd0, 0, "load15");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd2, 0, "sat_hold_up1");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd2, 0, "sat_hold_up2");

        applyStimulus(1, 1, 4'd9, 1, 0, 2'd3, 0, "load_over_en");

        applyStimulus(1, 1, 4'd13, 0, 0, 2'd0, 0, "load13");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd2, 0, "exact_top");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd0, 0, "step_zero");
        applyStimulus(1, 0, 4'd0, 0, 1, 2'd3, 0, "hold");

        applyStimulus(1, 1, 4'd3, 0, 0, 2'd0, 0, "load3");
        applyStimulus(1, 0, 4'd0, 1, 1, 2'd3, 0, "exact_zero");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd1, 0, "dir_up");
        applyStimulus(1, 0, 4'd0, 1, 1, 2'd2, 0, "dir_down");

        applyStimulus(1, 0, 4'd0, 1, 0, 2'd3, 0, "counting");
        applyStimulus(0, 1, 4'd7, 1, 0, 2'd3, 1, "reset_over_load");

        applyStimulus(1, 1, 4'd15, 0, 0, 2'd0, 0, "sticky_load");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd1, 0, "sticky_set");
        applyStimulus(1, 0, 4'd0, 0, 0, 2'd0, 0, "sticky_idle1");
        applyStimulus(1, 0, 4'd0, 0, 0, 2'd0, 0, "sticky_idle2");
        applyStimulus(1, 0, 4'd0, 0, 0, 2'd0, 0, "sticky_idle3");
        applyStimulus(1, 1, 4'd15, 0, 0, 2'd0, 0, "sticky_reload");
        applyStimulus(1, 0, 4'd0, 1, 0, 2'd1, 1, "sticky_set_wins");
        applyStimulus(1, 0, 4'd0, 0, 0, 2'd0, 1, "sticky_clear");
        applyStimulus(1, 0, 4'd0, 0, 0, 2'd0, 0, "sticky_cleared");

        for (int k = 0; k < 400; k++) begin
            bit r, l, e, d, c;
            logic [3:0] lv;
            logic [1:0] st;
            r  = ($urandom_range(0, 99) >= 3);
            l  = ($urandom_range(0, 99) < 10);
            e  = ($urandom_range(0, 99) < 75);
            d  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 99) < 15);
            lv = 4'($urandom_range(0, 15));
            st = 2'($urandom_range(0, 3));
            applyStimulus(r, l, lv, e, d, st, c, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_incrementer.md
PC_INCREMENTER -- requirements
Module: pc_incrementer

Interface
REQ-001 Parameter: WIDTH, 8, count width in bits (legal range 2..32).
REQ-002 Parameter: STEP_W, 2, width of the step input (legal range 1..WIDTH).
REQ-003 Parameter: SATURATE, 0, boundary mode (0 = wrap modulo 2^WIDTH, 1 = clamp at the boundary).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: en  input  1  count enable; applies one step per cycle while high.
REQ-007 Port: dir  input  1  direction (0 = up/add, 1 = down/subtract).
REQ-008 Port: step  input  STEP_W  unsigned step magnitude, 0..2^STEP_W-1.
REQ-009 Port: load  input  1  synchronous load request.
REQ-010 Port: load_val  input  WIDTH  value written on load.
REQ-011 Port: count  output  WIDTH  registered count value.
REQ-012 Port: carry  output  1  registered one-cycle pulse marking overflow (up) or underflow (down) on the step just applied.
REQ-013 Port: stat  output  1  registered boundary-status flag; behaviour per REQ-030/031.
REQ-014 Port: stat_clr  input  1  clears stat; present only when the macro is defined.

Function
REQ-015 Priority, highest first: reset, load, en; all other cycles hold count.
REQ-016 Load: count <= load_val on the next edge; carry <= 0; stat is not set; en and dir are ignored that cycle.
REQ-017 Up step: compute a (WIDTH+1)-bit sum = {0,count} + zero-extended step; overflow = sum[WIDTH].
REQ-018 Down step: compute a (WIDTH+1)-bit diff = {0,count} - zero-extended step; underflow = diff[WIDTH] (step > count).
REQ-019 SATURATE=0: count <= low WIDTH bits of sum/diff (wrap-around), including on overflow/underflow.
REQ-020 SATURATE=1: on overflow count <= all ones; on underflow count <= 0; otherwise as REQ-019.
REQ-021 carry <= 1 exactly in the cycle following an enabled step with overflow/underflow; otherwise carry <= 0.
REQ-022 step = 0 with en = 1: count unchanged, carry <= 0.
REQ-023 Exact boundary hit (e.g. up to all ones, or down to 0) is not overflow/underflow; carry <= 0.
REQ-024 Saturated count held at a boundary and stepped further in the same direction re-asserts carry on each such step.
REQ-025 Latency: count, carry, and stat reflect the inputs sampled at edge N from edge N; no combinational input-to-output path.
REQ-026 dir may change every cycle; each step uses the dir sampled on the same edge.

Reset
REQ-027 On a rising clk edge with rst_n = 0: count <= 0, carry <= 0, stat <= 0.
REQ-028 Reset overrides load, en, and stat_clr in the same cycle, including in mid-count or during a saturated hold.
REQ-029 First step after reset release uses count = 0.

Configuration
REQ-030 Macro PC_INCREMENTER_STICKY_STAT_EN defined: stat_clr port exists; stat sets on any carry event and holds until stat_clr = 1; simultaneous set and clear leaves stat = 1 (set wins).
REQ-031 Macro undefined: no stat_clr port; stat equals carry (one-cycle pulse, identical timing).

Verification
REQ-032 WIDTH=4, SATURATE=0, count=14, en=1, dir=0, step=3 -> next count=1, carry=1 for one cycle.
REQ-033 WIDTH=4, SATURATE=1, count=2, dir=1, step=3 -> count=0, carry=1; next cycle with the same inputs -> count=0, carry=1 again.
REQ-034 load=1, load_val=9, en=1, step=3 in the same cycle -> count=9, carry=0.
REQ-035 count=13, up, step=2 -> count=15, carry=0 (exact boundary); step=0 -> count=15, carry=0.
REQ-036 Counting with rst_n=0 asserted alongside load=1 -> count=0, carry=0, stat=0 on the next edge.
REQ-037 Macro defined: overflow event, then 3 idle cycles -> stat=1 throughout; carry event coincident with stat_clr=1 -> stat=1; stat_clr alone -> stat=0.
